fp_seq_divider: RTL and testbench
=================================

// Module: fp_seq_divider
// PURPOSE
//  IEEE-754 single-precision divider, result = a / b; the inverse operator of the
//  combinational FP tree multiplier in the ALU FP datapath.
//  Iterative radix-2 restoring mantissa division, one quotient bit per clock,
//  with a valid/ready handshake. Flags: overflow (as the multiplier) and div_by_zero.
//  Subnormal inputs are flushed to zero. Subnormal results are flushed to signed zero.
// PARAMETERS
//  EXP_W   8   exponent width
//  MAN_W   23  stored mantissa width
//  Q_BITS  26  quotient bits generated (24 significant + guard + round). Must equal MAN_W+3.
// PORTS
//  clk          in   1   single clock, rising edge
//  rst          in   1   asynchronous, active-high reset
//  in_valid     in   1   operands a/b present
//  in_ready     out  1   high only in IDLE; accept = in_valid & in_ready
//  a            in   32  dividend (FP32)
//  b            in   32  divisor (FP32)
//  out_valid    out  1   one-cycle pulse: result/flags valid
//  result       out  32  quotient (FP32); held until the next completion
//  overflow     out  1   finite/finite result rounded to >= 2^128 -> +/-inf
//  div_by_zero  out  1   finite nonzero / zero
// BEHAVIOUR
//  Reset: state=IDLE. Registered outputs after reset: out_valid=0, result=0,
//   overflow=0, div_by_zero=0. in_ready=1 (decoded from IDLE).
//  FSM: IDLE -accept,special-> DONE
//       IDLE -accept,normal--> DIV
//       DIV -Q_BITS iterations-> NORM -> DONE -> IDLE
//  Timing: accept edge = cycle 0.
//   Special operands: out_valid high in cycle 1.
//   Normal operands: out_valid high in cycle Q_BITS+2 (=28).
//   Next accept possible in the cycle after DONE.
//  in_valid while not in IDLE is ignored. Operands are captured only at accept.
//  Sign = sa ^ sb for every non-NaN result.
//  Special cases (E=exponent field; E==0 counts as zero):
//   either operand NaN       -> 7FC00000
//   0/0 or inf/inf           -> 7FC00000
//   inf/finite               -> signed inf, flags 0
//   finite/inf or 0/nonzero  -> signed zero
//   nonzero finite/0         -> signed inf, div_by_zero=1
//  Normal path: mantissas with hidden 1 (24b); exp = ea - eb + 127, kept 10b signed.
//   Restoring divide: remainder width MAN_W+2. If ma < mb, pre-shift the dividend
//   left by 1 and decrement exp, so quotient MSB=1 (no post-normalisation).
//  NORM: round to nearest even using guard, round bit, and sticky (remainder != 0).
//   A mantissa carry-out increments exp. Then:
//   exp >= 255 -> signed inf, overflow=1
//   exp <= 0   -> signed zero, flags 0
//  Flags are valid only with out_valid. Both flags are cleared on every completion.
//  Reset mid-operation: abort immediately. No out_valid for the aborted op;
//   result/flags return to 0.
// STRUCTURE
//  Shared include fp_defs.vh holds: EXP_BIAS=127, QNAN=32'h7FC00000, INF_MAG=31'h7F800000,
//   operand class codes (ZERO, NORM, INF, NAN), and the FSM state encoding.
//   The multiplier can reuse the same classes.
//  One sub-module: fp_div_mant_core. It holds the remainder/quotient registers and
//   iteration counter, and does one restoring step per cycle.
//   Ports: start, ma, mb, done, quotient[Q_BITS-1:0], sticky.
//  Classification, exponent arithmetic, rounding, packing and the FSM are in the top level.
// TESTING
//  1) 40C00000 / 40000000 (6/2) -> 40400000, ovf=0, dbz=0, out_valid exactly cycle 28.
//  2) 3F800000 / 40400000 (1/3) -> 3EAAAAAB (RNE). C1200000 / 41A00000 -> BF000000.
//  3) 7F7FFFFF / 3F000000 (max/0.5) -> 7F800000, overflow=1.
//     00800000 / 40000000 -> 00000000, overflow=0.
//  4) 3F800000 / 00000000 -> 7F800000, dbz=1. 00000000 / 00000000 -> 7FC00000.
//     7F800000 / 7F800000 -> 7FC00000. All at cycle 1.
//  5) Handshake: hold in_valid high with new operands during a divide -> in_ready=0,
//     only the first op is accepted. Back-to-back: second accept the cycle after DONE.
//  6) Assert rst at cycle 10 of 6/2 -> no out_valid, outputs 0, in_ready=1.
//     A following 1/3 still gives 3EAAAAAB.
//  Plus a random sweep of normal operands checked against $bitstoshortreal division
//   with the flush-to-zero rules applied.

Source files
------------

// File: rtl/fp_seq_divider_pkg.sv
// Shared definitions for the FP32 divider: constants, operand classes and FSM states.
// The operand classes are also meant for reuse by the FP multiplier.
package fp_seq_divider_pkg;

    localparam int          EXP_BIAS = 127;
    localparam logic [31:0] QNAN     = 32'h7FC00000;
    localparam logic [30:0] INF_MAG  = 31'h7F800000;

    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,
        CLS_NORM = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } fp_class_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_NORM = 2'd2,
        ST_DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/fp_div_mant_core.sv
// Radix-2 restoring mantissa divider: one quotient bit per clock after start.
// done is high during the cycle whose clock edge takes the final step.
module fp_div_mant_core #(
    parameter int MAN_W  = 23,
    parameter int Q_BITS = 26
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [MAN_W+1:0]    ma,
    input  logic [MAN_W:0]      mb,
    output logic                done,
    output logic [Q_BITS-1:0]   quotient,
    output logic                sticky
);

    localparam int CW = $clog2(Q_BITS + 1);

    logic [CW-1:0]    cnt;
    logic             busy;
    logic [MAN_W+1:0] rem;
    logic [MAN_W+1:0] divisor;
    logic             ge;
    logic [MAN_W+1:0] diff;

    assign ge     = (rem >= divisor);
    assign diff   = ge ? (rem - divisor) : rem;
    assign done   = busy && (cnt == CW'(1));
    assign sticky = |rem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= CW'(Q_BITS);
        end else if (busy) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1))
                busy <= 1'b0;
        end
    end

    // The partial remainder stays below 2*mb, so the left shift never loses a bit.
    always_ff @(posedge clk) begin
        if (start) begin
            rem      <= ma;
            divisor  <= {1'b0, mb};
            quotient <= '0;
        end else if (busy) begin
            rem      <= diff << 1;
            quotient <= {quotient[Q_BITS-2:0], ge};
        end
    end

endmodule

// File: rtl/fp_seq_divider.sv
// Sequential IEEE-754 single-precision divider (a / b) with valid/ready handshake.
// Subnormal operands and results are flushed to signed zero; rounding is nearest-even.
module fp_seq_divider
    import fp_seq_divider_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 23,
    parameter int Q_BITS = 26
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [EXP_W+MAN_W:0]       a,
    input  logic [EXP_W+MAN_W:0]       b,
    output logic                       out_valid,
    output logic [EXP_W+MAN_W:0]       result,
    output logic                       overflow,
    output logic                       div_by_zero
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int EW = EXP_W + 2;
    localparam logic [EXP_W-1:0]     EXP_ONES = '1;
    localparam logic signed [EW-1:0] BIAS_S   = EW'(EXP_BIAS);
    localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] EXP_ZERO = '0;

    function automatic fp_class_t classify(input logic [W-1:0] x);
        if (x[W-2:MAN_W] == '0)
            return CLS_ZERO;
        if (x[W-2:MAN_W] == EXP_ONES)
            return (x[MAN_W-1:0] != '0) ? CLS_NAN : CLS_INF;
        return CLS_NORM;
    endfunction

    // Returns {overflow, packed result}. q[Q_BITS-1] is always 1 thanks to the pre-shift.
    function automatic logic [W:0] round_pack(
        input logic                 s,
        input logic signed [EW-1:0] e,
        input logic [Q_BITS-1:0]    q,
        input logic                 st
    );
        logic [MAN_W:0]       m;
        logic                 up;
        logic [MAN_W+1:0]     mr;
        logic signed [EW-1:0] e2;
        m  = q[Q_BITS-1:2];
        up = q[1] & (q[0] | st | m[0]);
        mr = {1'b0, m} + {{(MAN_W+1){1'b0}}, up};
        e2 = e + $signed({{(EW-1){1'b0}}, mr[MAN_W+1]});
        if (e2 >= EXP_MAX)
            return {1'b1, s, INF_MAG};
        if (e2 <= EXP_ZERO)
            return {1'b0, s, {(W-1){1'b0}}};
        return {1'b0, s, e2[EXP_W-1:0], mr[MAN_W-1:0]};
    endfunction

    div_state_t           state;
    fp_class_t            cls_a, cls_b;
    logic                 sa, sb, sq;
    logic [EXP_W-1:0]     ea, eb;
    logic [MAN_W:0]       ma, mb;
    logic                 pre_shift;
    logic [MAN_W+1:0]     dividend;
    logic signed [EW-1:0] exp_init;
    logic                 accept;
    logic                 is_special;
    logic [W-1:0]         spec_res;
    logic                 spec_dbz;

    logic                 sign_q;
    logic signed [EW-1:0] exp_q;
    logic [W-1:0]         res_q;
    logic                 ovf_q;
    logic                 dbz_q;

    logic                 core_done;
    logic [Q_BITS-1:0]    quotient;
    logic                 sticky;

    assign sa        = a[W-1];
    assign sb        = b[W-1];
    assign sq        = sa ^ sb;
    assign ea        = a[W-2:MAN_W];
    assign eb        = b[W-2:MAN_W];
    assign ma        = {1'b1, a[MAN_W-1:0]};
    assign mb        = {1'b1, b[MAN_W-1:0]};
    assign cls_a     = classify(a);
    assign cls_b     = classify(b);
    assign in_ready  = (state == ST_IDLE);
    assign accept    = in_valid & in_ready;

    // Pre-shifting a smaller dividend keeps the quotient in [1,2).
    assign pre_shift = (ma < mb);
    assign dividend  = pre_shift ? {ma, 1'b0} : {1'b0, ma};
    assign exp_init  = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS_S
                       - $signed({{(EW-1){1'b0}}, pre_shift});

    always_comb begin
        is_special = 1'b1;
        spec_res   = QNAN;
        spec_dbz   = 1'b0;
        if (cls_a == CLS_NAN || cls_b == CLS_NAN)
            spec_res = QNAN;
        else if ((cls_a == CLS_ZERO && cls_b == CLS_ZERO) || (cls_a == CLS_INF && cls_b == CLS_INF))
            spec_res = QNAN;
        else if (cls_a == CLS_INF)
            spec_res = {sq, INF_MAG};
        else if (cls_b == CLS_INF || cls_a == CLS_ZERO)
            spec_res = {sq, {(W-1){1'b0}}};
        else if (cls_b == CLS_ZERO) begin
            spec_res = {sq, INF_MAG};
            spec_dbz = 1'b1;
        end else
            is_special = 1'b0;
    end

    fp_div_mant_core #(
        .MAN_W  (MAN_W),
        .Q_BITS (Q_BITS)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .start    (accept & ~is_special),
        .ma       (dividend),
        .mb       (mb),
        .done     (core_done),
        .quotient (quotient),
        .sticky   (sticky)
    );

    // Staged result: special results land at accept, normal ones are rounded in NORM.
    always_ff @(posedge clk) begin
        if (accept) begin
            sign_q <= sq;
            exp_q  <= exp_init;
            res_q  <= spec_res;
            ovf_q  <= 1'b0;
            dbz_q  <= spec_dbz;
        end else if (state == ST_NORM) begin
            {ovf_q, res_q} <= round_pack(sign_q, exp_q, quotient, sticky);
            dbz_q          <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            out_valid   <= 1'b0;
            result      <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                ST_IDLE: if (accept) state <= is_special ? ST_DONE : ST_DIV;
                ST_DIV:  if (core_done) state <= ST_NORM;
                ST_NORM: state <= ST_DONE;
                ST_DONE: begin
                    out_valid   <= 1'b1;
                    result      <= res_q;
                    overflow    <= ovf_q;
                    div_by_zero <= dbz_q;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_seq_divider.sv
// Bench for fp_seq_divider: directed vectors with literal expectations plus a
// real-arithmetic reference model checked by a scoreboard on every completion.
module tb_fp_seq_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic        out_valid;
    logic [31:0] result;
    logic        overflow;
    logic        div_by_zero;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        dbz;
        int          acc;
        int          lat;
    } exp_t;
    exp_t sb_q[$];

    fp_seq_divider dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .result      (result),
        .overflow    (overflow),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total = total + 1;
        if (act !== req) begin
            bad = bad + 1;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic real to_real(input logic [31:0] x);
        return $bitstoreal({x[31], 11'(int'(x[30:23]) + 896), x[22:0], 29'd0});
    endfunction

    // Exact double quotient rounded to FP32 (nearest-even), then overflow/flush rules.
    function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic o, output logic d,
                                  output int lat);
        logic        s, xz, yz, xi, yi, xn, yn, up;
        logic [63:0] db;
        logic [52:0] m;
        logic [23:0] m24;
        logic [24:0] m25;
        int          fe;
        s   = x[31] ^ y[31];
        o   = 1'b0;
        d   = 1'b0;
        lat = 1;
        xz  = (x[30:23] == 8'h00);
        yz  = (y[30:23] == 8'h00);
        xi  = (x[30:23] == 8'hFF) && (x[22:0] == 0);
        yi  = (y[30:23] == 8'hFF) && (y[22:0] == 0);
        xn  = (x[30:23] == 8'hFF) && (x[22:0] != 0);
        yn  = (y[30:23] == 8'hFF) && (y[22:0] != 0);
        if (xn || yn || (xz && yz) || (xi && yi))
            r = 32'h7FC00000;
        else if (xi)
            r = {s, 31'h7F800000};
        else if (yi || xz)
            r = {s, 31'h0};
        else if (yz) begin
            r = {s, 31'h7F800000};
            d = 1'b1;
        end else begin
            lat = 28;
            db  = $realtobits(to_real(x) / to_real(y));
            m   = {1'b1, db[51:0]};
            m24 = m[52:29];
            up  = m[28] && ((m[27:0] != 0) || m24[0]);
            m25 = {1'b0, m24} + 25'(up);
            fe  = int'(db[62:52]) - 1023 + 127;
            if (m25[24])
                fe = fe + 1;
            if (fe >= 255) begin
                r = {s, 31'h7F800000};
                o = 1'b1;
            end else if (fe <= 0)
                r = {s, 31'h0};
            else
                r = {s, fe[7:0], m25[22:0]};
        end
    endfunction

    // Scoreboard: record accepts, check every completion against the model.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb_q.delete();
        end else begin
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    check("sb_spurious_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_result", result, e.res);
                    check("sb_overflow", 32'(overflow), 32'(e.ovf));
                    check("sb_div_by_zero", 32'(div_by_zero), 32'(e.dbz));
                    check("sb_latency", 32'(cyc - e.acc), 32'(e.lat));
                end
            end
            if (in_valid && in_ready) begin
                model(a, b, e.res, e.ovf, e.dbz, e.lat);
                e.acc = cyc + 1;
                sb_q.push_back(e);
            end
        end
    end

    task automatic issue(input logic [31:0] x, input logic [31:0] y, output int acc);
        int n;
        @(posedge clk);
        #1;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        n        = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100)
            check("issue_in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        acc      = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output logic got, output int when_c, output logic [31:0] r,
                            output logic o, output logic d);
        got    = 1'b0;
        when_c = 0;
        r      = '0;
        o      = 1'b0;
        d      = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (out_valid) begin
                got    = 1'b1;
                when_c = cyc;
                r      = result;
                o      = overflow;
                d      = div_by_zero;
            end
        end
    endtask

    task automatic do_op(input string name, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] er, input logic eo, input logic ed, input int el);
        logic [31:0] mr, r;
        logic        mo, md, got, o, d;
        int          ml, acc, when_c;
        model(x, y, mr, mo, md, ml);
        check({name, "_model_res"}, mr, er);
        check({name, "_model_ovf"}, 32'(mo), 32'(eo));
        check({name, "_model_dbz"}, 32'(md), 32'(ed));
        issue(x, y, acc);
        wait_out(got, when_c, r, o, d);
        if (!got) begin
            check({name, "_timeout"}, 32'(got), 32'd1);
        end else begin
            check({name, "_res"}, r, er);
            check({name, "_ovf"}, 32'(o), 32'(eo));
            check({name, "_dbz"}, 32'(d), 32'(ed));
            check({name, "_lat"}, 32'(when_c - acc), 32'(el));
        end
    endtask

    initial begin
        logic [31:0] r, x, y;
        logic        got, o, d;
        int          acc1, acc2, acc, when_c, n, busy_ready, ov_cnt;

        rst      = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_div_by_zero", 32'(div_by_zero), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        do_op("six_by_two",  32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 28);
        do_op("one_third",   32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 1'b0, 28);
        do_op("neg_half",    32'hC1200000, 32'h41A00000, 32'hBF000000, 1'b0, 1'b0, 28);
        do_op("max_by_half", 32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 1'b1, 1'b0, 28);
        do_op("underflow",   32'h00800000, 32'h40000000, 32'h00000000, 1'b0, 1'b0, 28);
        do_op("one_by_zero", 32'h3F800000, 32'h00000000, 32'h7F800000, 1'b0, 1'b1, 1);
        do_op("zero_zero",   32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b0, 1);
        do_op("inf_inf",     32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b0, 1'b0, 1);
        do_op("nan_in",      32'h3F800000, 32'h7FC00001, 32'h7FC00000, 1'b0, 1'b0, 1);
        do_op("ninf_by_two", 32'hFF800000, 32'h40000000, 32'hFF800000, 1'b0, 1'b0, 1);
        do_op("two_by_ninf", 32'h40000000, 32'hFF800000, 32'h80000000, 1'b0, 1'b0, 1);
        do_op("subn_a",      32'h80000001, 32'h40000000, 32'h80000000, 1'b0, 1'b0, 1);

        // Hold in_valid through a divide; operands change after the first accept.
        @(posedge clk);
        #1;
        a        = 32'h40C00000;
        b        = 32'h40000000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        acc1 = cyc;
        a    = 32'h3F800000;
        b    = 32'h40400000;
        busy_ready = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (in_ready) busy_ready++;
        end
        check("hs_in_ready_busy", 32'(busy_ready), 32'd0);
        wait_out(got, when_c, r, o, d);
        check("hs_first_got", 32'(got), 32'd1);
        check("hs_first_res", r, 32'h40400000);
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        acc2 = cyc + 1;
        check("hs_second_accept", 32'(acc2 - acc1), 32'd29);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_out(got, when_c, r, o, d);
        check("hs_second_res", r, 32'h3EAAAAAB);
        check("hs_second_lat", 32'(when_c - acc2), 32'd28);

        // Reset in the middle of a divide aborts it.
        issue(32'h40C00000, 32'h40000000, acc);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_overflow", 32'(overflow), 32'd0);
        check("abort_div_by_zero", 32'(div_by_zero), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        ov_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) ov_cnt++;
        end
        check("abort_no_out_valid", 32'(ov_cnt), 32'd0);
        do_op("after_abort", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 1'b0, 28);

        // Random normal operands; the scoreboard checks each completion.
        for (int i = 0; i < 60; i++) begin
            x = {1'(($urandom)), 8'(i < 30 ? $urandom_range(100, 154) : $urandom_range(1, 254)),
                 23'($urandom)};
            y = {1'(($urandom)), 8'(i < 30 ? $urandom_range(100, 154) : $urandom_range(1, 254)),
                 23'($urandom)};
            issue(x, y, acc);
            wait_out(got, when_c, r, o, d);
            if (!got)
                check("rand_timeout", 32'(got), 32'd1);
        end

        repeat (3) @(posedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
